// File: rtl/text_console_pkg.sv
// Shared definitions for the text console writer: geometry defaults,
// cell bit positions, control codes, FSM states and cursor operations.
// Build option: TEXT_CONSOLE_SCROLL_EN enables scrolling on last-row newline.
package text_console_pkg;

    localparam int DEFAULT_COLS = 40;
    localparam int DEFAULT_ROWS = 30;
    localparam int ADDR_W       = 11;

    // Cell word bit positions, shared with the video driver
    localparam int CURSOR    = 14;
    localparam int BLINK     = 13;
    localparam int INVERTED  = 12;
    localparam int RED       = 11;
    localparam int GREEN     = 10;
    localparam int BLUE      = 9;
    localparam int INTENSITY = 8;

    // Control codes handled by the writer
    localparam logic [7:0] CH_BS = 8'h08;
    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_FF = 8'h0C;
    localparam logic [7:0] CH_CR = 8'h0D;

    // Attribute used by the power-up clear: white, normal intensity
    localparam logic [5:0] INIT_ATTR = 6'b0_0_111_0;

    typedef enum logic [3:0] {
        INIT_CLR,
        IDLE,
        DECODE,
        PUT,
        CUR_CLR_RD,
        CUR_CLR_WR,
`ifdef TEXT_CONSOLE_SCROLL_EN
        SCR_RD,
        SCR_WR,
`endif
        LINE_CLR,
        CUR_SET_RD,
        CUR_SET_WR
    } state_e;

    // What the latched byte asks for
    typedef enum logic [2:0] {
        OP_NONE,
        OP_PUT,
        OP_NL,
        OP_BS,
        OP_FF
    } op_e;

    // Cursor counter commands
    typedef enum logic [2:0] {
        CUR_HOLD,
        CUR_INC,
        CUR_DEC,
        CUR_NL,
        CUR_HOME
    } cur_op_e;

    // 0x20..0x7E and 0x80..0xFF are drawn as glyphs
    function automatic logic is_printable(input logic [7:0] b);
        return (b >= 8'h20) && (b != 8'h7F);
    endfunction

    // Classify a non-printable byte
    function automatic op_e decode_ctrl(input logic [7:0] b);
        case (b)
            CH_CR, CH_LF: return OP_NL;
            CH_BS:        return OP_BS;
            CH_FF:        return OP_FF;
            default:      return OP_NONE;
        endcase
    endfunction

endpackage

// File: rtl/text_console_writer_cursor.sv
// console_cursor: row/col position counter with increment (wrapping into a
// newline), decrement, newline and home, plus the linear cell address.
// With TEXT_CONSOLE_SCROLL_EN a newline on the last row keeps the row
// (the caller scrolls); without it the row wraps to 0.
module console_cursor
    import text_console_pkg::*;
#(
    parameter int COLS = DEFAULT_COLS,
    parameter int ROWS = DEFAULT_ROWS,
    localparam int COL_W = $clog2(COLS),
    localparam int ROW_W = $clog2(ROWS)
) (
    input  logic              sys_clk,
    input  logic              reset,
    input  cur_op_e           op,
    output logic [ADDR_W-1:0] addr,
    output logic              col_last,
    output logic              row_last
);

    logic [ROW_W-1:0] row_q, row_d, next_row;
    logic [COL_W-1:0] col_q, col_d;

    assign col_last = (col_q == COL_W'(COLS - 1));
    assign row_last = (row_q == ROW_W'(ROWS - 1));
    assign addr     = ADDR_W'(row_q) * ADDR_W'(COLS) + ADDR_W'(col_q);

`ifdef TEXT_CONSOLE_SCROLL_EN
    assign next_row = row_last ? row_q : row_q + 1'b1;
`else
    assign next_row = row_last ? '0 : row_q + 1'b1;
`endif

    // Next position for the requested cursor command
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
        row_d = row_q;
        col_d = col_q;
        case (op)
            CUR_INC: begin
                if (col_last) begin
                    col_d = '0;
                    row_d = next_row;
                end else begin
                    col_d = col_q + 1'b1;
                end
            end
            CUR_NL: begin
                col_d = '0;
                row_d = next_row;
            end
            CUR_DEC: begin
                if (col_q != '0) begin
                    col_d = col_q - 1'b1;
                end else if (row_q != '0) begin
                    row_d = row_q - 1'b1;
                    col_d = COL_W'(COLS - 1);
                end
            end
            CUR_HOME: begin
                row_d = '0;
                col_d = '0;
            end
            default: ;
        endcase
    end

    // Position register
    always_ff @(posedge sys_clk or posedge reset) begin
        // NOTE: clocked state uses non-blocking assignments so all flops update together.
        if (reset) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

endmodule

// File: rtl/text_console_writer.sv
// text_console_writer: byte-stream front end for the 40x30 text video
// driver. Renders bytes and control codes into video RAM and keeps the
// cursor bit (cell bit 14) on the current position.
// Build option: TEXT_CONSOLE_SCROLL_EN scrolls on a last-row newline;
// otherwise the cursor wraps to row 0 and row 0 is cleared.
module text_console_writer
    import text_console_pkg::*;
#(
    parameter int COLS = DEFAULT_COLS,
    parameter int ROWS = DEFAULT_ROWS
) (
    input  logic        sys_clk,
    input  logic        reset,
    input  logic        char_valid,
    input  logic [7:0]  char_data,
    output logic        char_ready,
    input  logic [5:0]  attr,
    output logic        mem_we,
    output logic [10:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    output logic        busy
);

    localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(COLS * ROWS - 1);
    localparam logic [ADDR_W-1:0] COLS_A    = ADDR_W'(COLS);
`ifdef TEXT_CONSOLE_SCROLL_EN
    localparam logic [ADDR_W-1:0] LAST_ROW_BASE = ADDR_W'((ROWS - 1) * COLS);
`endif
    localparam logic [15:0] CURSOR_MASK = 16'(1) << CURSOR;

    state_e            state_q, state_d;
    op_e               op_q, op_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [ADDR_W-1:0] end_q, end_d;
    logic [7:0]        byte_q, byte_d;
    logic [5:0]        attr_q, attr_d;

    cur_op_e           cur_op;
    logic [ADDR_W-1:0] cur_addr;
    logic              col_last, row_last;
    logic              start_wrap;

    console_cursor #(
        .COLS (COLS),
        .ROWS (ROWS)
    ) u_cursor (
        .sys_clk  (sys_clk),
        .reset    (reset),
        .op       (cur_op),
        .addr     (cur_addr),
        .col_last (col_last),
        .row_last (row_last)
    );

    assign busy = ~char_ready;

    // FSM next state, cursor commands and the single RAM access of this cycle
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        idx_d      = idx_q;
        end_d      = end_q;
        byte_d     = byte_q;
        attr_d     = attr_q;
        cur_op     = CUR_HOLD;
        start_wrap = 1'b0;
        char_ready = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;

        case (state_q)
            INIT_CLR: begin
                // Power-up repaint behaves like a form feed in white
                attr_d  = INIT_ATTR;
                op_d    = OP_FF;
                idx_d   = '0;
                end_d   = LAST_CELL;
                state_d = LINE_CLR;
            end
            IDLE: begin
                char_ready = 1'b1;
                if (char_valid) begin
                    byte_d = char_data;
                    attr_d = attr;
                    if (is_printable(char_data)) begin
                        op_d    = OP_PUT;
                        state_d = PUT;
                    end else begin
                        op_d    = decode_ctrl(char_data);
                        state_d = DECODE;
                    end
                end
            end
            DECODE: begin
                case (op_q)
                    OP_NL, OP_BS: state_d = CUR_CLR_RD;
                    OP_FF: begin
                        idx_d   = '0;
                        end_d   = LAST_CELL;
                        state_d = LINE_CLR;
                    end
                    default: state_d = IDLE;
                endcase
            end
            PUT: begin
                // Writing the glyph also drops the cursor bit from this cell
                mem_we    = 1'b1;
                mem_addr  = cur_addr;
                mem_wdata = {2'b00, attr_q, byte_q};
                cur_op    = CUR_INC;
                if (col_last && row_last) start_wrap = 1'b1;
                else                      state_d    = CUR_SET_RD;
            end
            CUR_CLR_RD: begin
                mem_addr = cur_addr;
                state_d  = CUR_CLR_WR;
            end
            CUR_CLR_WR: begin
                mem_we    = 1'b1;
                mem_addr  = cur_addr;
                mem_wdata = mem_rdata & ~CURSOR_MASK;
                if (op_q == OP_BS) begin
                    cur_op  = CUR_DEC;
                    state_d = CUR_SET_WR;
                end else begin
                    cur_op = CUR_NL;
                    if (row_last) start_wrap = 1'b1;
                    else          state_d    = CUR_SET_RD;
                end
            end
`ifdef TEXT_CONSOLE_SCROLL_EN
            SCR_RD: begin
                mem_addr = idx_q;
                state_d  = SCR_WR;
            end
            SCR_WR: begin
                // Each cell moves up one row; then the bottom row is blanked
                mem_we    = 1'b1;
                mem_addr  = idx_q - COLS_A;
                mem_wdata = mem_rdata;
                if (idx_q == LAST_CELL) begin
                    idx_d   = LAST_ROW_BASE;
                    end_d   = LAST_CELL;
                    state_d = LINE_CLR;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = SCR_RD;
                end
            end
`endif
            LINE_CLR: begin
                mem_we    = 1'b1;
                mem_addr  = idx_q;
                mem_wdata = {2'b00, attr_q, 8'h00};
                if (idx_q == end_q) begin
                    if (op_q == OP_FF) begin
                        cur_op  = CUR_HOME;
                        state_d = CUR_SET_WR;
                    end else begin
                        state_d = CUR_SET_RD;
                    end
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            CUR_SET_RD: begin
                mem_addr = cur_addr;
                state_d  = CUR_SET_WR;
            end
            CUR_SET_WR: begin
                // Backspace and form feed overwrite the cell; others keep its content
                mem_we   = 1'b1;
                mem_addr = cur_addr;
                if (op_q == OP_BS || op_q == OP_FF) mem_wdata = {2'b01, attr_q, 8'h00};
                else                                mem_wdata = mem_rdata | CURSOR_MASK;
                state_d  = IDLE;
            end
            default: state_d = INIT_CLR;
        endcase

        // Newline on the last row: scroll up, or wrap to row 0 and blank it
        if (start_wrap) begin
`ifdef TEXT_CONSOLE_SCROLL_EN
            idx_d   = COLS_A;
            state_d = SCR_RD;
`else
            idx_d   = '0;
            end_d   = COLS_A - 1'b1;
            state_d = LINE_CLR;
`endif
        end
    end

    // FSM and datapath registers
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            state_q <= INIT_CLR;
            op_q    <= OP_NONE;
            idx_q   <= '0;
            end_q   <= '0;
            byte_q  <= '0;
            attr_q  <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            idx_q   <= idx_d;
            end_q   <= end_d;
            byte_q  <= byte_d;
            attr_q  <= attr_d;
        end
    end

endmodule

// File: tb/tb_text_console_writer.sv
// Directed bench for text_console_writer with a behavioural video RAM
// (write on clock, read data valid one cycle after the address).
module tb_text_console_writer;

    logic        sys_clk = 1'b0;
    logic        reset = 1'b1;
    logic        char_valid = 1'b0;
    logic [7:0]  char_data = 8'h00;
    logic [5:0]  attr = 6'h00;
    logic        char_ready;
    logic        mem_we;
    logic [10:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        busy;

    logic [15:0] vram [0:2047];
    int          checks = 0;
    int          errors = 0;
    int          wr_cnt = 0;

    text_console_writer dut (
        .sys_clk    (sys_clk),
        .reset      (reset),
        .char_valid (char_valid),
        .char_data  (char_data),
        .char_ready (char_ready),
        .attr       (attr),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .busy       (busy)
    );

    always #5 sys_clk = ~sys_clk;

    // Video RAM model and write counter
    always @(posedge sys_clk) begin
        if (mem_we) begin
            vram[mem_addr] <= mem_wdata;
            wr_cnt <= wr_cnt + 1;
        end
        mem_rdata <= vram[mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int count_bad(input int lo, input int hi, input logic [15:0] exp);
        int n = 0;
        for (int i = lo; i <= hi; i++) if (vram[i] !== exp) n++;
        return n;
    endfunction

    // Wait for ready (bounded), then transfer one byte
    task automatic offer(input logic [7:0] b, input logic [5:0] a);
        int n = 0;
        while (char_ready !== 1'b1 && n < 6000) begin
            @(posedge sys_clk); #1;
            n++;
        end
        if (n >= 6000) check("offer_timeout", 32'(n), 32'd0);
        char_valid = 1'b1;
        char_data  = b;
        attr       = a;
        @(posedge sys_clk); #1;
        char_valid = 1'b0;
    endtask

    // Edges from the transfer edge until ready is seen again
    task automatic wait_idle(input int start, output int lat);
        lat = start;
        while (char_ready !== 1'b1 && lat < 6000) begin
            @(posedge sys_clk); #1;
            lat++;
        end
    endtask

    task automatic send(input logic [7:0] b, input logic [5:0] a, output int lat);
        offer(b, a);
        wait_idle(1, lat);
    endtask

    initial begin
        int lat;
        int base;

        // Reset state
        #1;
        check("rst_we", 32'(mem_we), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_wdata", 32'(mem_wdata), 32'd0);
        check("rst_ready", 32'(char_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd1);
        repeat (3) @(negedge sys_clk);
        reset = 1'b0;

        // Power-up clear
        base = wr_cnt;
        wait_idle(0, lat);
        check("init_writes", 32'(wr_cnt - base), 32'd1201);
        check("init_cell0", 32'(vram[0]), 32'h4E00);
        check("init_blank", 32'(count_bad(1, 1199, 16'h0E00)), 32'd0);
        check("init_ready", 32'(char_ready), 32'd1);

        // Printable byte
        send(8'h41, 6'h0F, lat);
        check("A_lat", 32'(lat), 32'd4);
        check("A_cell0", 32'(vram[0]), 32'h0F41);
        check("A_cell1", 32'(vram[1]), 32'h4E00);

        // Ignored control byte
        base = wr_cnt;
        send(8'h07, 6'h0F, lat);
        check("bel_lat", 32'(lat), 32'd2);
        check("bel_writes", 32'(wr_cnt - base), 32'd0);

        // Carriage return moves to the next row
        send(8'h0D, 6'h0F, lat);
        check("cr_lat", 32'(lat), 32'd6);
        check("cr_old", 32'(vram[1]), 32'h0E00);
        check("cr_new", 32'(vram[40]), 32'h4E00);

        // Form feed
        base = wr_cnt;
        send(8'h0C, 6'h0F, lat);
        check("ff_lat", 32'(lat), 32'd1203);
        check("ff_writes", 32'(wr_cnt - base), 32'd1201);
        check("ff_cell0", 32'(vram[0]), 32'h4F00);
        check("ff_cell40", 32'(vram[40]), 32'h0F00);

        // A full row of 'x' wraps to row 1
        for (int i = 0; i < 40; i++) send(8'h78, 6'h12, lat);
        check("wrap_lat", 32'(lat), 32'd4);
        check("wrap_cell0", 32'(vram[0]), 32'h1278);
        check("wrap_cell39", 32'(vram[39]), 32'h1278);
        check("wrap_cell40", 32'(vram[40]), 32'h4F00);

        // Backspace at column 0 goes to the end of the previous row
        send(8'h08, 6'h12, lat);
        check("bs_lat", 32'(lat), 32'd5);
        check("bs_cell39", 32'(vram[39]), 32'h5200);
        check("bs_cell40", 32'(vram[40]), 32'h0F00);

        // Fill: 'Z' in cell 40, then walk the cursor to row 29
        send(8'h0C, 6'h0E, lat);
        send(8'h0A, 6'h0E, lat);
        send(8'h5A, 6'h0F, lat);
        for (int i = 0; i < 28; i++) send(8'h0A, 6'h0E, lat);
        check("row29_cursor", 32'(vram[1160]), 32'h4E00);
        check("row1_Z", 32'(vram[40]), 32'h0F5A);

        // Newline on the last row
        base = wr_cnt;
        send(8'h0A, 6'h0E, lat);
`ifdef TEXT_CONSOLE_SCROLL_EN
        check("scr_lat", 32'(lat), 32'd2366);
        check("scr_writes", 32'(wr_cnt - base), 32'd1202);
        check("scr_cell0", 32'(vram[0]), 32'h0F5A);
        check("scr_cell40", 32'(vram[40]), 32'h0E00);
        check("scr_cursor", 32'(vram[1160]), 32'h4E00);
        check("scr_lastrow", 32'(count_bad(1161, 1199, 16'h0E00)), 32'd0);
`else
        check("wrap0_lat", 32'(lat), 32'd46);
        check("wrap0_writes", 32'(wr_cnt - base), 32'd42);
        check("wrap0_cursor", 32'(vram[0]), 32'h4E00);
        check("wrap0_row0", 32'(count_bad(1, 39, 16'h0E00)), 32'd0);
        check("wrap0_cell40", 32'(vram[40]), 32'h0F5A);
        check("wrap0_cell1160", 32'(vram[1160]), 32'h0E00);
`endif

        // Reset in the middle of a long operation
`ifdef TEXT_CONSOLE_SCROLL_EN
        offer(8'h0A, 6'h0E);
`else
        offer(8'h0C, 6'h0E);
`endif
        repeat (50) @(posedge sys_clk);
        #1;
        check("mid_busy", 32'(busy), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_we", 32'(mem_we), 32'd0);
        check("mid_rst_addr", 32'(mem_addr), 32'd0);
        check("mid_rst_wdata", 32'(mem_wdata), 32'd0);
        check("mid_rst_ready", 32'(char_ready), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd1);
        repeat (2) @(negedge sys_clk);
        reset = 1'b0;
        base = wr_cnt;
        wait_idle(0, lat);
        check("reinit_writes", 32'(wr_cnt - base), 32'd1201);
        check("reinit_cell0", 32'(vram[0]), 32'h4E00);
        check("reinit_blank", 32'(count_bad(1, 1199, 16'h0E00)), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
